alu_issuer: RTL and testbench

Command-side initiator for the 7-op ALU. Accepts one operation at a time over a valid/ready command channel and drives the ALU operand and opcode inputs. Holds those inputs stable for the ALU's registered-opcode latency, then captures the ALU result and zero flag and returns them on a valid/ready response channel. Sits between the sequencing logic and the ALU instance, on the same `clk`.

---
 rtl/alu_issuer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issuer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// -----------------------------------------------------------------------------
// alu_issuer
//
// Command-side initiator for the 7-op ALU. Accepts one operation at a time on
// a valid/ready command channel, drives the ALU opcode/operand inputs and holds
// them stable for LAT cycles. It then captures the ALU result and zero flag and
// returns them on a valid/ready response channel.
//
// Parameters
//   WIDTH : operand/result width
//   LAT   : ALU cycles from a stable opcode/operand set to a settled result
//
// Ports
//   clk, rst                    : clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_op, cmd_a, cmd_b        : opcode and operands
//   alu_op, alu_a, alu_b        : registered drive into the ALU
//   alu_result, alu_zero        : ALU outputs
//   rsp_valid/rsp_ready         : response handshake
//   rsp_result, rsp_zero        : captured ALU outputs
//   rsp_err                     : opcode was not a legal ALU opcode
//   rsp_mismatch                : captured values disagree with internal model
//
// Build option
//   ALU_ISSUER_CHECK_EN : when defined, an internal reference model checks the
//                         captured result; otherwise rsp_mismatch is tied to 0.
// -----------------------------------------------------------------------------
module alu_issuer #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             rsp_mismatch
);

  localparam int             CW    = $clog2(LAT + 1) + 1;
  localparam logic [CW-1:0]  LAT_C = CW'(LAT);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             capture;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

  // Async reset holds state at IDLE, so gate with rst to keep the channel
  // closed while reset is asserted.
  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = (state_q == RESP);
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

  // The ALU result is settled once the counter has reached LAT.
  assign capture = (state_q == WAIT) && (cnt_q == LAT_C);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_op_d  = cmd_op;
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          rsp_err_d = !op_legal(cmd_op);
          cnt_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (capture) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  // Reference model evaluated on the registered operands, which stay stable
  // from acceptance through capture. Illegal opcodes expect 0.
  logic [WIDTH-1:0] exp_result;
  logic             rsp_mismatch_q, rsp_mismatch_d;

  always_comb begin
    exp_result = '0;
    case (alu_op_q)
      OP_ADD: exp_result = alu_a_q + alu_b_q;
      OP_SUB: exp_result = alu_a_q - alu_b_q;
      OP_AND: exp_result = alu_a_q & alu_b_q;
      OP_OR:  exp_result = alu_a_q | alu_b_q;
      OP_XOR: exp_result = alu_a_q ^ alu_b_q;
      OP_NOR: exp_result = ~(alu_a_q | alu_b_q);
      OP_SLT: exp_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a_q) < $signed(alu_b_q))};
      default: exp_result = '0;
    endcase
  end

  always_comb begin
    rsp_mismatch_d = rsp_mismatch_q;
    if (capture) begin
      rsp_mismatch_d = (alu_result != exp_result) ||
                       (alu_zero != (exp_result == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_mismatch_q <= 1'b0;
    end else begin
      rsp_mismatch_q <= rsp_mismatch_d;
    end
  end

  assign rsp_mismatch = rsp_mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_issuer
//
// Directed bench for alu_issuer with WIDTH=32, LAT=2. A small behavioural ALU
// with a two-register result pipeline sits on the ALU side; it can be forced
// to return a wrong value to exercise the mismatch flag.
// -----------------------------------------------------------------------------
module tb_alu_issuer;

  localparam int WIDTH = 32;
  localparam int LAT   = 2;

`ifdef ALU_ISSUER_CHECK_EN
  localparam logic CHK_EXP = 1'b1;
`else
  localparam logic CHK_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic             rsp_mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issuer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err),
    .rsp_mismatch (rsp_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: combinational function followed by two result registers.
  logic             stub_en = 1'b0;
  logic [WIDTH-1:0] alu_f;
  logic [WIDTH-1:0] pipe1 = '0;
  logic [WIDTH-1:0] pipe2 = '0;

  always_comb begin
    alu_f = '0;
    case (alu_op)
      4'b0000: alu_f = alu_a + alu_b;
      4'b0010: alu_f = alu_a - alu_b;
      4'b0100: alu_f = alu_a & alu_b;
      4'b0101: alu_f = alu_a | alu_b;
      4'b0110: alu_f = alu_a ^ alu_b;
      4'b0111: alu_f = ~(alu_a | alu_b);
      4'b1010: alu_f = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_f = '0;
    endcase
  end

  always @(posedge clk) begin
    pipe1 <= alu_f;
    pipe2 <= pipe1;
  end

  assign alu_result = stub_en ? 32'd1 : pipe2;
  assign alu_zero   = stub_en ? 1'b0  : (pipe2 == '0);

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return #1 after the accepting edge.
  task automatic accept_op(input string tag, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_eq({tag, "_ready_timeout"}, 64'(guard < 20), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check_eq({tag, "_alu_op"}, 64'(alu_op), 64'(op));
    check_eq({tag, "_alu_a"},  64'(alu_a),  64'(a));
    check_eq({tag, "_alu_b"},  64'(alu_b),  64'(b));
  endtask

  // Called #1 after acceptance: measure latency, check response, handshake.
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] res,
                           input logic z, input logic err, input logic mm);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check_eq({tag, "_latency"},  64'(cyc),          64'(LAT + 1));
    check_eq({tag, "_result"},   64'(rsp_result),   64'(res));
    check_eq({tag, "_zero"},     64'(rsp_zero),     64'(z));
    check_eq({tag, "_err"},      64'(rsp_err),      64'(err));
    check_eq({tag, "_mismatch"}, 64'(rsp_mismatch), 64'(mm));
    $display("txn %s: result=0x%08h zero=%0b err=%0b mismatch=%0b latency=%0d",
             tag, rsp_result, rsp_zero, rsp_err, rsp_mismatch, cyc);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res, input logic z,
                        input logic err, input logic mm);
    accept_op(tag, op, a, b);
    finish_op(tag, res, z, err, mm);
  endtask

  initial begin
    logic seen_valid;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    repeat (2) tick();
    check_eq("rst_cmd_ready",  64'(cmd_ready),    64'd0);
    check_eq("rst_rsp_valid",  64'(rsp_valid),    64'd0);
    check_eq("rst_alu_op",     64'(alu_op),       64'd0);
    check_eq("rst_alu_a",      64'(alu_a),        64'd0);
    check_eq("rst_rsp_result", 64'(rsp_result),   64'd0);
    check_eq("rst_rsp_err",    64'(rsp_err),      64'd0);
    check_eq("rst_mismatch",   64'(rsp_mismatch), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Directed vectors with hand-computed results.
    run_op("add_5_7",   4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0);
    run_op("sub_9_9",   4'b0010, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b0);
    run_op("slt_m1_1",  4'b1010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0);
    run_op("slt_1_m1",  4'b1010, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0);
    run_op("nor_0_0",   4'b0111, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0);
    run_op("illegal",   4'b0011, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1'b0);
    run_op("and",       4'b0100, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0);
    run_op("or",        4'b0101, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1'b0, 1'b0);
    run_op("xor",       4'b0110, 32'h0000_00AA,  32'h0000_00FF,  32'h0000_0055,  1'b0, 1'b0, 1'b0);
    run_op("sub_wrap",  4'b0010, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0);
    run_op("add_wrap",  4'b0000, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 1'b0, 1'b0);

    // Backpressure: a second command is held through WAIT and a 5-cycle stall.
    accept_op("stall", 4'b0000, 32'd3, 32'd4);
    cmd_op    = 4'b0100;
    cmd_a     = 32'h0000_F0F0;
    cmd_b     = 32'h0000_FF00;
    cmd_valid = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      check_eq("stall_wait_ready", 64'(cmd_ready), 64'd0);
      check_eq("stall_wait_op",    64'(alu_op),    64'd0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid",  64'(rsp_valid),  64'd1);
      check_eq("stall_result", 64'(rsp_result), 64'd7);
      check_eq("stall_zero",   64'(rsp_zero),   64'd0);
      check_eq("stall_err",    64'(rsp_err),    64'd0);
      check_eq("stall_ready",  64'(cmd_ready),  64'd0);
      check_eq("stall_op",     64'(alu_op),     64'd0);
      tick();
    end
    $display("txn stall: result=0x%08h held for 5 cycles", rsp_result);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("stall_rel_valid", 64'(rsp_valid), 64'd0);
    check_eq("stall_rel_ready", 64'(cmd_ready), 64'd1);
    check_eq("stall_rel_op",    64'(alu_op),    64'd0);
    tick();
    cmd_valid = 1'b0;
    check_eq("held_cmd_op", 64'(alu_op), 64'h4);
    check_eq("held_cmd_a",  64'(alu_a),  64'h0000_F0F0);
    finish_op("held_and", 32'h0000_F000, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT discards the operation.
    accept_op("rst_mid", 4'b0110, 32'h1234_5678, 32'h0F0F_0F0F);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_mid_alu_op",    64'(alu_op),    64'd0);
    check_eq("rst_mid_alu_a",     64'(alu_a),     64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_rel_alu_op",    64'(alu_op),    64'd0);
    check_eq("rst_rel_alu_a",     64'(alu_a),     64'd0);
    check_eq("rst_rel_alu_b",     64'(alu_b),     64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen_valid = 1'b1;
    end
    check_eq("rst_mid_no_rsp", 64'(seen_valid), 64'd0);
    $display("txn rst_mid: operation discarded, rsp_valid seen=%0b", seen_valid);

    // rsp_ready asserted in IDLE has no effect.
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    check_eq("idle_rsp_ready_valid", 64'(rsp_valid), 64'd0);
    check_eq("idle_rsp_ready_cmd",   64'(cmd_ready), 64'd1);

    // Faulty ALU: returns 1 for 2+2.
    stub_en = 1'b1;
    run_op("stub_2_2", 4'b0000, 32'd2, 32'd2, 32'd1, 1'b0, 1'b0, CHK_EXP);
    stub_en = 1'b0;

    // Mismatch clears on the next correct result.
    run_op("post_stub", 4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
